// File: rtl/pc_flow_pkg.sv
// Shared types and defaults for the PC-update sequencer.
// Redirect sources are ranked by priority: a taken branch in EX beats any jump in ID.
package pc_flow_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_JMP = 2'd1,
        SRC_JR  = 2'd2,
        SRC_BR  = 2'd3
    } redir_src_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

    // An ID jump is on the wrong path when EX resolves a taken branch in the same cycle.
    function automatic redir_src_e redirect_src(input logic br_taken,
                                                input logic jump,
                                                input logic jump_src);
        redir_src_e src;
        if (br_taken) begin
            src = SRC_BR;
        end else if (jump) begin
            src = jump_src ? SRC_JR : SRC_JMP;
        end else begin
            src = SRC_SEQ;
        end
        return src;
    endfunction

endpackage

// File: rtl/pc_flow_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
// The count holds at all-ones rather than wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_flow_ctrl.sv
// PC-update sequencer: arbitrates redirects, applies load-use stalls, holds PC during fetch waits
// and replays a redirect that arrived while the fetch was outstanding.
module pc_flow_ctrl
    import pc_flow_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_ready,
    input  logic [31:0]      pc_plus4,
    input  logic             id_jump,
    input  logic             id_jump_src,
    input  logic [31:0]      id_jump_target,
    input  logic [31:0]      id_jr_target,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    input  logic             ld_use_hazard,
    output logic             pc_we,
    output logic [31:0]      pc_next,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    state_e      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    redir_src_e  src_s;
    logic [31:0] target_s;
    logic        redirect_commit_s;
    logic        stall_inc_s;

    // Priority select of the redirect target and all PC/pipeline controls.
    always_comb begin
        src_s = redirect_src(ex_branch_taken, id_jump, id_jump_src);
        case (src_s)
            SRC_BR:  target_s = ex_branch_target;
            SRC_JR:  target_s = id_jr_target;
            SRC_JMP: target_s = id_jump_target;
            default: target_s = pc_plus4;
        endcase

        state_d           = state_q;
        pend_target_d     = pend_target_q;
        pc_we             = 1'b0;
        pc_next           = pc_plus4;
        if_id_we          = 1'b0;
        if_id_flush       = 1'b0;
        id_ex_flush       = 1'b0;
        redirect_commit_s = 1'b0;

        if (reset) begin
            pc_next     = RESET_PC;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (src_s != SRC_SEQ) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = (src_s == SRC_BR);
                        if (imem_ready) begin
                            pc_we             = 1'b1;
                            pc_next           = target_s;
                            redirect_commit_s = 1'b1;
                        end else begin
                            pend_target_d = target_s;
                            state_d       = ST_PEND;
                        end
                    end else if (ld_use_hazard) begin
                        id_ex_flush = 1'b1;
                    end else if (imem_ready) begin
                        pc_we    = 1'b1;
                        if_id_we = 1'b1;
                    end else begin
                        if_id_flush = 1'b1;
                    end
                end
                ST_PEND: begin
                    // ID holds a bubble here, so only EX branches and load-use matter.
                    if_id_flush = 1'b1;
                    id_ex_flush = ex_branch_taken | ld_use_hazard;
                    if (ex_branch_taken) begin
                        pend_target_d = ex_branch_target;
                    end else begin
                        pend_target_d = pend_target_q;
                    end
                    if (imem_ready) begin
                        pc_we             = 1'b1;
                        pc_next           = ex_branch_taken ? ex_branch_target : pend_target_q;
                        redirect_commit_s = 1'b1;
                        state_d           = ST_RUN;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    if_id_flush = 1'b1;
                end
            endcase
        end

        stall_inc_s = ~pc_we & ~reset;
    end

    // State and pending-redirect registers; reset discards any pending target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pend_target_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign redirect_pending = (state_q == ST_PEND);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_commit_s),
        .count (redirect_count)
    );

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Scoreboard bench for pc_flow_ctrl: a reference model pushes expected outputs per driven cycle,
// and the sampled DUT outputs are popped and compared against them.
module tb_pc_flow_ctrl;

    localparam int          CW    = 4;
    localparam logic [31:0] RSTPC = 32'h0040_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_ready = 1'b0;
    logic [31:0]   pc_plus4 = 32'h0;
    logic          id_jump = 1'b0;
    logic          id_jump_src = 1'b0;
    logic [31:0]   id_jump_target = 32'h0;
    logic [31:0]   id_jr_target = 32'h0;
    logic          ex_branch_taken = 1'b0;
    logic [31:0]   ex_branch_target = 32'h0;
    logic          ld_use_hazard = 1'b0;
    logic          pc_we, if_id_we, if_id_flush, id_ex_flush, redirect_pending;
    logic [31:0]   pc_next;
    logic [CW-1:0] stall_cycles, redirect_count;

    pc_flow_ctrl #(.RESET_PC(RSTPC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .pc_plus4(pc_plus4),
        .id_jump(id_jump), .id_jump_src(id_jump_src), .id_jump_target(id_jump_target),
        .id_jr_target(id_jr_target), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .ld_use_hazard(ld_use_hazard),
        .pc_we(pc_we), .pc_next(pc_next), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .redirect_pending(redirect_pending),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          cmp_pc;
        logic          pc_we;
        logic [31:0]   pc_next;
        logic          if_id_we;
        logic          if_id_flush;
        logic          id_ex_flush;
        logic          pend;
        logic [CW-1:0] stall;
        logic [CW-1:0] redir;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic          m_pend = 1'b0, m_pend_n;
    logic [31:0]   m_tgt = 32'h0, m_tgt_n;
    logic [CW-1:0] m_stall = '0, m_stall_n;
    logic [CW-1:0] m_redir = '0, m_redir_n;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
        return (inc && v != {CW{1'b1}}) ? v + 1'b1 : v;
    endfunction

    // Reference behaviour for the current inputs and model state; also forms the model's next state.
    function automatic exp_t predict();
        exp_t        e;
        logic        redir;
        logic [31:0] tgt;
        logic        commit;
        e.cmp_pc = 1'b0; e.pc_we = 1'b0; e.pc_next = pc_plus4; e.if_id_we = 1'b0;
        e.if_id_flush = 1'b0; e.id_ex_flush = 1'b0;
        e.pend = m_pend; e.stall = m_stall; e.redir = m_redir;
        commit = 1'b0;
        m_pend_n = m_pend; m_tgt_n = m_tgt;
        redir = ex_branch_taken | id_jump;
        tgt = ex_branch_taken ? ex_branch_target : (id_jump_src ? id_jr_target : id_jump_target);
        if (reset) begin
            e.cmp_pc = 1'b1; e.pc_next = RSTPC; e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
            e.pend = 1'b0; e.stall = '0; e.redir = '0;
            m_pend_n = 1'b0; m_tgt_n = 32'h0;
        end else if (!m_pend) begin
            if (redir) begin
                e.if_id_flush = 1'b1;
                e.id_ex_flush = ex_branch_taken;
                if (imem_ready) begin
                    e.pc_we = 1'b1; e.pc_next = tgt; commit = 1'b1;
                end else begin
                    m_pend_n = 1'b1; m_tgt_n = tgt;
                end
            end else if (ld_use_hazard) e.id_ex_flush = 1'b1;
            else if (imem_ready) begin
                e.pc_we = 1'b1; e.if_id_we = 1'b1;
            end else e.if_id_flush = 1'b1;
        end else begin
            e.if_id_flush = 1'b1;
            e.id_ex_flush = ex_branch_taken | ld_use_hazard;
            if (ex_branch_taken) m_tgt_n = ex_branch_target;
            if (imem_ready) begin
                e.pc_we = 1'b1; commit = 1'b1; m_pend_n = 1'b0;
                e.pc_next = ex_branch_taken ? ex_branch_target : m_tgt;
            end
        end
        if (e.pc_we) e.cmp_pc = 1'b1;
        m_stall_n = reset ? '0 : sat_inc(m_stall, ~e.pc_we);
        m_redir_n = reset ? '0 : sat_inc(m_redir, commit);
        return e;
    endfunction

    // One cycle: predict and push, sample mid-cycle and pop-compare, then advance the model at the edge.
    task automatic step(input string tag);
        exp_t e;
        sb_q.push_back(predict());
        #2;
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, ".pc_we"}, {31'h0, pc_we}, {31'h0, e.pc_we});
            if (e.cmp_pc) check_eq({tag, ".pc_next"}, pc_next, e.pc_next);
            check_eq({tag, ".if_id_we"}, {31'h0, if_id_we}, {31'h0, e.if_id_we});
            check_eq({tag, ".if_id_flush"}, {31'h0, if_id_flush}, {31'h0, e.if_id_flush});
            check_eq({tag, ".id_ex_flush"}, {31'h0, id_ex_flush}, {31'h0, e.id_ex_flush});
            check_eq({tag, ".pend"}, {31'h0, redirect_pending}, {31'h0, e.pend});
            check_eq({tag, ".stall"}, {28'h0, stall_cycles}, {28'h0, e.stall});
            check_eq({tag, ".redir"}, {28'h0, redirect_count}, {28'h0, e.redir});
        end
        @(posedge clk);
        m_pend = m_pend_n; m_tgt = m_tgt_n; m_stall = m_stall_n; m_redir = m_redir_n;
        @(negedge clk);
    endtask

    task automatic drive(input logic rdy, input logic jmp, input logic jsrc, input logic br,
                         input logic ld);
        imem_ready = rdy; id_jump = jmp; id_jump_src = jsrc; ex_branch_taken = br;
        ld_use_hazard = ld;
    endtask

    initial begin
        id_jump_target   = 32'h0040_0800;
        id_jr_target     = 32'h0040_0200;
        ex_branch_target = 32'h0040_0100;
        @(negedge clk);
        step("reset0");
        step("reset1");
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            pc_plus4 = 32'h0040_0004 + 32'(4 * i);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("seq");
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step("lduse");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("after_lduse");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); step("br_over_jmp");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("after_br");

        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step("jr_wait0");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("jr_wait1");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); step("jr_wait2");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("jr_replay");

        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step("pend_enter");
        ex_branch_target = 32'h0040_0300;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step("pend_br");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("pend_br_replay");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step("pend_enter2");
        ex_branch_target = 32'h0040_0500;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step("pend_br_ready");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("run_idle");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); step("jr_ready");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step("br_wait");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("br_replay");

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step("stall_sat");
        end
        check_eq("stall_saturated", {28'h0, stall_cycles}, 32'h0000_000F);

        for (int i = 0; i < 40; i++) begin
            pc_plus4         = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} | 32'h0040_0000;
            id_jump_target   = pc_plus4 + 32'h0000_1000;
            id_jr_target     = pc_plus4 + 32'h0000_2000;
            ex_branch_target = pc_plus4 + 32'h0000_3000;
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 3) == 0));
            step("rand");
        end

        pc_plus4 = 32'h0040_0010; id_jr_target = 32'h0040_0200;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step("pre_reset_pend");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; step("reset_mid_pend");
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("no_replay");
        check_eq("no_replay_pc", pc_next, 32'h0040_0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
